// File: rtl/ntt_pkg.sv
// Shared types and width constants for the NTT operand feeder.
// DATA_SIZE_ARB gives the coefficient width and defaults to 32 when the build does not set it.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

package ntt_pkg;
    localparam int DATA_SIZE = `DATA_SIZE_ARB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ntt_state_t;
endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register that carries butterfly write-back information.
// Asynchronous active-low reset clears every stage, so no write survives a reset.
module ntt_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/ntt_operand_feeder.sv
// Forward NTT read/write-back address scheduler feeding a PE_Tilde butterfly unit.
// Optional macro NTT_INV_EN adds inv_i, which offsets twiddle addresses by N for the inverse.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

// Handshake: start_i is taken on its rising edge in IDLE only; pe_valid_o and wr_en_o
// are single-cycle qualifiers with no back-pressure; done_o pulses once per schedule.
module ntt_operand_feeder
    import ntt_pkg::*;
#(
    parameter int N      = 256,
    parameter int LOGN   = $clog2(N),
    parameter int DATA_W = `DATA_SIZE_ARB,
    parameter int PE_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
`ifdef NTT_INV_EN
    input  logic              inv_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [LOGN-1:0]   coef_raddr_top_o,
    output logic [LOGN-1:0]   coef_raddr_bot_o,
    output logic [LOGN:0]     tw_raddr_o,
    input  logic [DATA_W-1:0] coef_rdata_top_i,
    input  logic [DATA_W-1:0] coef_rdata_bot_i,
    input  logic [DATA_W-1:0] tw_rdata_i,
    output logic [DATA_W-1:0] data_top_o,
    output logic [DATA_W-1:0] data_bot_o,
    output logic [DATA_W-1:0] twiddle_o,
    output logic              pe_valid_o,
    output logic              wr_en_o,
    output logic [LOGN-1:0]   wr_addr_top_o,
    output logic [LOGN-1:0]   wr_addr_bot_o,
    output ntt_state_t        state_o
);
    localparam int DL_W = 2 + 2 * LOGN;

    ntt_state_t      state, state_nxt;
    logic [LOGN-1:0] stage, bfly;
    logic            start_q, inv_q, issue, issue_q, last_q, wr_last;
    logic            last_bfly, last_stage, drain_exit;
    logic [LOGN-1:0] sh, m_c, g_c, j_c, top_c, bot_c;
    logic [LOGN:0]   tw_c;
    logic [DL_W-1:0] dl_out;

    assign last_bfly  = (bfly == LOGN'(N / 2 - 1));
    assign last_stage = (stage == LOGN'(LOGN - 1));
    assign drain_exit = (state == DRAIN) && wr_en_o && wr_last;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:  if (start_i && !start_q) state_nxt = ISSUE;
            ISSUE: begin
                issue = 1'b1;
                if (last_bfly) state_nxt = DRAIN;
            end
            DRAIN: if (drain_exit) state_nxt = last_stage ? DONE : ISSUE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Span m = N>>(s+1) is formed as 1<<sh so g and j reduce to shift and mask.
    always_comb begin
        sh    = LOGN'(LOGN - 1) - stage;
        m_c   = LOGN'(1) << sh;
        g_c   = bfly >> sh;
        j_c   = bfly & (m_c - LOGN'(1));
        top_c = (g_c << (sh + LOGN'(1))) | j_c;
        bot_c = top_c + m_c;
        tw_c  = ((LOGN+1)'(1) << stage) + {1'b0, g_c};
        if (inv_q) tw_c = tw_c + (LOGN+1)'(N);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            stage            <= '0;
            bfly             <= '0;
            start_q          <= 1'b0;
            inv_q            <= 1'b0;
            issue_q          <= 1'b0;
            last_q           <= 1'b0;
            pe_valid_o       <= 1'b0;
            coef_raddr_top_o <= '0;
            coef_raddr_bot_o <= '0;
            tw_raddr_o       <= '0;
        end else begin
            state      <= state_nxt;
            start_q    <= start_i;
            issue_q    <= issue;
            last_q     <= issue && last_bfly;
            pe_valid_o <= issue_q;
            if (state == IDLE && start_i && !start_q) begin
                stage <= '0;
                bfly  <= '0;
`ifdef NTT_INV_EN
                inv_q <= inv_i;
`else
                inv_q <= 1'b0;
`endif
            end
            if (issue) begin
                coef_raddr_top_o <= top_c;
                coef_raddr_bot_o <= bot_c;
                tw_raddr_o       <= tw_c;
                bfly             <= last_bfly ? '0 : bfly + LOGN'(1);
            end
            if (drain_exit) stage <= last_stage ? '0 : stage + LOGN'(1);
        end
    end

    // One extra stage covers the RAM read cycle between address and pe_valid_o.
    ntt_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PE_LAT + 1)
    ) u_wb_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({issue_q, last_q, coef_raddr_top_o, coef_raddr_bot_o}),
        .dout  (dl_out)
    );

    assign wr_en_o       = dl_out[DL_W-1];
    assign wr_last       = dl_out[DL_W-2];
    assign wr_addr_top_o = dl_out[2*LOGN-1:LOGN];
    assign wr_addr_bot_o = dl_out[LOGN-1:0];

    assign data_top_o = pe_valid_o ? coef_rdata_top_i : '0;
    assign data_bot_o = pe_valid_o ? coef_rdata_bot_i : '0;
    assign twiddle_o  = pe_valid_o ? tw_rdata_i : '0;
    assign busy_o     = (state == ISSUE) || (state == DRAIN);
    assign done_o     = (state == DONE);
    assign state_o    = state;
endmodule

// File: tb/tb_ntt_operand_feeder.sv
// Self-checking bench for ntt_operand_feeder at N=8, PE_LAT=3, with bench-side RAM/ROM models.
// Define NTT_INV_EN to also exercise inverse twiddle addressing.
module tb_ntt_operand_feeder;
    import ntt_pkg::*;

    localparam int N      = 8;
    localparam int LOGN   = 3;
    localparam int DW     = DATA_SIZE;
    localparam int PE_LAT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            inv;
    logic            busy_o, done_o, pe_valid_o, wr_en_o;
    logic [LOGN-1:0] coef_raddr_top_o, coef_raddr_bot_o, wr_addr_top_o, wr_addr_bot_o;
    logic [LOGN:0]   tw_raddr_o;
    logic [DW-1:0]   rd_top, rd_bot, rd_tw, data_top_o, data_bot_o, twiddle_o;
    ntt_state_t      state_o;

    logic [63:0] exp_q[$];
    logic [63:0] wr_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pv_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_operand_feeder #(.N(N), .LOGN(LOGN), .DATA_W(DW), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .reset(reset), .start_i(start),
`ifdef NTT_INV_EN
        .inv_i(inv),
`endif
        .busy_o(busy_o), .done_o(done_o),
        .coef_raddr_top_o(coef_raddr_top_o), .coef_raddr_bot_o(coef_raddr_bot_o),
        .tw_raddr_o(tw_raddr_o),
        .coef_rdata_top_i(rd_top), .coef_rdata_bot_i(rd_bot), .tw_rdata_i(rd_tw),
        .data_top_o(data_top_o), .data_bot_o(data_bot_o), .twiddle_o(twiddle_o),
        .pe_valid_o(pe_valid_o), .wr_en_o(wr_en_o),
        .wr_addr_top_o(wr_addr_top_o), .wr_addr_bot_o(wr_addr_bot_o),
        .state_o(state_o)
    );

    function automatic logic [DW-1:0] f_top(input int a); return DW'(32'h1000 + a * 3); endfunction
    function automatic logic [DW-1:0] f_bot(input int a); return DW'(32'h2000 + a * 5); endfunction
    function automatic logic [DW-1:0] f_tw(input int a);  return DW'(32'h3000 + a * 7); endfunction

    // Synchronous-read memories with one-cycle latency.
    always @(posedge clk) begin
        rd_top <= f_top(int'(coef_raddr_top_o));
        rd_bot <= f_bot(int'(coef_raddr_bot_o));
        rd_tw  <= f_tw(int'(tw_raddr_o));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Packs {stage, b, top, bot, tw} for each butterfly of a full schedule.
    task automatic push_sched(input bit inv_mode);
        int m, g, j, top, bot, tw;
        for (int s = 0; s < LOGN; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                m   = N >> (s + 1);
                g   = b / m;
                j   = b % m;
                top = g * 2 * m + j;
                bot = top + m;
                tw  = (1 << s) + g + (inv_mode ? N : 0);
                exp_q.push_back({8'(s), 8'(b), 16'(top), 16'(bot), 16'(tw)});
            end
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e, w;
        if (done_o) done_cnt++;
        if (pe_valid_o) begin
            pv_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pe_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (e[55:48] == 8'd0 && e[63:56] != 8'd0)
                    chk("raw_hazard_pending_writes", wr_q.size(), 0);
                chk("data_top", data_top_o, f_top(int'(e[47:32])));
                chk("data_bot", data_bot_o, f_bot(int'(e[31:16])));
                chk("twiddle", twiddle_o, f_tw(int'(e[15:0])));
                wr_q.push_back({32'(cyc + PE_LAT), e[47:32], e[31:16]});
            end
        end
        if (wr_en_o) begin
            if (wr_q.size() == 0) begin
                chk("spurious_wr_en", 1, 0);
            end else begin
                w = wr_q.pop_front();
                chk("wr_cycle", cyc, w[63:32]);
                chk("wr_addr_top", wr_addr_top_o, w[31:16]);
                chk("wr_addr_bot", wr_addr_bot_o, w[15:0]);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_raddr_top"}, coef_raddr_top_o, 0);
        chk({tag, "_raddr_bot"}, coef_raddr_bot_o, 0);
        chk({tag, "_tw_raddr"}, tw_raddr_o, 0);
        chk({tag, "_data_top"}, data_top_o, 0);
        chk({tag, "_data_bot"}, data_bot_o, 0);
        chk({tag, "_twiddle"}, twiddle_o, 0);
        chk({tag, "_pe_valid"}, pe_valid_o, 0);
        chk({tag, "_wr_en"}, wr_en_o, 0);
        chk({tag, "_wr_addr_top"}, wr_addr_top_o, 0);
        chk({tag, "_wr_addr_bot"}, wr_addr_bot_o, 0);
        chk({tag, "_state"}, 64'(state_o), 64'(IDLE));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    task automatic end_of_run(input string tag, input int done_exp);
        repeat (4) @(negedge clk);
        chk({tag, "_busy_low"}, busy_o, 0);
        chk({tag, "_exp_q_empty"}, exp_q.size(), 0);
        chk({tag, "_wr_q_empty"}, wr_q.size(), 0);
        chk({tag, "_pe_valid_count"}, pv_cnt, 12);
        chk({tag, "_done_count"}, done_cnt, done_exp);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        inv   = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(posedge clk); #1 reset = 1'b1;

        // Single start pulse, full forward schedule.
        pv_cnt = 0; done_cnt = 0;
        push_sched(1'b0);
        pulse_start();
        wait_done("run1_done_seen");
        end_of_run("run1", 1);

        // start_i held high throughout: exactly one schedule.
        pv_cnt = 0; done_cnt = 0;
        push_sched(1'b0);
        @(posedge clk); #1 start = 1'b1;
        wait_done("held_done_seen");
        repeat (20) @(negedge clk);
        end_of_run("held", 1);
        #1 start = 1'b0;

        // Reset during stage 1, then restart from stage 0.
        pv_cnt = 0; done_cnt = 0;
        push_sched(1'b0);
        pulse_start();
        for (int k = 0; k < 200 && pv_cnt < 6; k++) @(negedge clk);
        chk("midrun_reached_stage1", pv_cnt >= 6, 1);
        @(posedge clk); #2 reset = 1'b0;
        exp_q.delete();
        wr_q.delete();
        #1 chk_zero("midrun_reset");
        repeat (6) @(negedge clk);
        chk("midrun_no_wr_in_reset", wr_en_o, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_idle_no_wr", wr_en_o, 0);
        pv_cnt = 0; done_cnt = 0;
        push_sched(1'b0);
        pulse_start();
        wait_done("restart_done_seen");
        end_of_run("restart", 1);

`ifdef NTT_INV_EN
        // Inverse twiddle addressing: every twiddle address offset by N.
        pv_cnt = 0; done_cnt = 0;
        inv = 1'b1;
        push_sched(1'b1);
        pulse_start();
        inv = 1'b0;
        wait_done("inv_done_seen");
        end_of_run("inv", 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
